// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: frame geometry and FSM state encoding.
`timescale 1ns/1ps
package spi_pkg;
   localparam int unsigned SPI_ADDR_W     = 7;
   localparam int unsigned SPI_DATA_W     = 8;
   localparam int unsigned SPI_FRAME_BITS = 16;
   localparam int unsigned SPI_CNT_W      = $clog2(SPI_FRAME_BITS);
   localparam logic        SPI_RW_READ    = 1'b1;

   typedef enum logic [2:0] {
      WAIT_IDLE = 3'd0,
      IDLE      = 3'd1,
      ADDR      = 3'd2,
      RW        = 3'd3,
      DATA      = 3'd4,
      DONE      = 3'd5
   } spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with registered rise/fall pulse detection.
//   clk, rst : system clock, async active-high reset
//   d_i      : asynchronous input pin
//   sync_o   : synchronized level (last stage)
//   rise_o   : one-clk pulse, aligned with sync_o going high
//   fall_o   : one-clk pulse, aligned with sync_o going low
`timescale 1ns/1ps
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);
   logic [SYNC_STAGES-1:0] sync_q;

   // Edges compare the last two stages so the pulse lands with the new level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         rise_o <= 1'b0;
         fall_o <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         rise_o <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
         fall_o <= ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_slave_regs.sv
// SPI responder with a local 8-bit register bank.
// Frame: 7-bit address MSB first, R/W bit (1 = read), 8 data bits MSB first.
//   clk, rst            : system clock, async active-high reset
//   sclk_in/cs_n_in/mosi: SPI pins from the master (oversampled)
//   miso, miso_oe       : read data and its drive enable
//   wr_pulse/addr/data  : committed-write notification (addr/data hold)
//   frame_done          : pulse per complete 16-bit frame
//   frame_err           : pulse when cs_n rises mid-frame
//   regs_flat           : register i at bits [8i+7:8i]
`timescale 1ns/1ps
module spi_slave_regs
   import spi_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  RESET_VAL   = 8'h00
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           sclk_in,
   input  logic                           cs_n_in,
   input  logic                           mosi,
   output logic                           miso,
   output logic                           miso_oe,
   output logic                           wr_pulse,
   output logic [SPI_ADDR_W-1:0]          wr_addr,
   output logic [SPI_DATA_W-1:0]          wr_data,
   output logic                           frame_done,
   output logic                           frame_err,
   output logic [NUM_REGS*SPI_DATA_W-1:0] regs_flat
);
   localparam int unsigned WAIT_W = $clog2(SYNC_STAGES + 1);

   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_n_s, cs_fall, cs_rise_unused;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic mosi_s;

   spi_state_e                               state_q;
   logic [WAIT_W-1:0]                        wait_cnt_q;
   logic [SPI_CNT_W-1:0]                     bit_cnt_q;
   logic [SPI_FRAME_BITS-2:0]                shift_q;
   logic [SPI_DATA_W-1:0]                    rd_q;
   logic [NUM_REGS-1:0][SPI_DATA_W-1:0]      regs_q;

   logic [SPI_ADDR_W-1:0] frame_addr_c;
   logic                  frame_rw_c;
   logic [SPI_DATA_W-1:0] frame_data_c;
   logic                  frame_addr_ok_c;
   logic [SPI_DATA_W-1:0] rd_byte_c;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
      .clk    (clk),
      .rst    (rst),
      .d_i    (sclk_in),
      .sync_o (sclk_s),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk    (clk),
      .rst    (rst),
      .d_i    (cs_n_in),
      .sync_o (cs_n_s),
      .rise_o (cs_rise_unused),
      .fall_o (cs_fall)
   );

   // mosi needs only the level path; it is sampled on the sclk rise pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mosi_sync_q <= '0;
      else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
   end
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // Fields of the completed frame as seen on the 16th sclk rise.
   assign frame_addr_c    = shift_q[14:8];
   assign frame_rw_c      = shift_q[7];
   assign frame_data_c    = {shift_q[6:0], mosi_s};
   assign frame_addr_ok_c = 32'(frame_addr_c) < NUM_REGS;

   // Read lookup at the R/W bit; out-of-range addresses read as zero.
   always_comb begin
      rd_byte_c = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (shift_q[6:0] == SPI_ADDR_W'(i)) rd_byte_c = regs_q[i];
      end
   end

   // Frame decoder and register bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= WAIT_IDLE;
         wait_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rd_q       <= '0;
         regs_q     <= {NUM_REGS{RESET_VAL}};
         miso       <= 1'b0;
         miso_oe    <= 1'b0;
         wr_pulse   <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         wr_pulse   <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;

         case (state_q)
            // cs_n must be seen high for longer than the synchronizer depth, so
            // reset-value ones still flushing out of the chain are not trusted.
            WAIT_IDLE: begin
               if (cs_n_s) begin
                  if (wait_cnt_q == WAIT_W'(SYNC_STAGES)) begin
                     wait_cnt_q <= '0;
                     state_q    <= IDLE;
                  end else begin
                     wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                  end
               end else begin
                  wait_cnt_q <= '0;
               end
            end

            IDLE: begin
               if (cs_fall) begin
                  bit_cnt_q <= '0;
                  shift_q   <= '0;
                  rd_q      <= '0;
                  state_q   <= ADDR;
               end
            end

            ADDR: begin
               if (cs_n_s) begin
                  frame_err <= 1'b1;
                  state_q   <= IDLE;
               end else if (sclk_rise) begin
                  shift_q   <= {shift_q[13:0], mosi_s};
                  bit_cnt_q <= bit_cnt_q + SPI_CNT_W'(1);
                  if (bit_cnt_q == SPI_CNT_W'(SPI_ADDR_W - 1)) state_q <= RW;
               end
            end

            RW: begin
               if (cs_n_s) begin
                  frame_err <= 1'b1;
                  state_q   <= IDLE;
               end else if (sclk_rise) begin
                  shift_q   <= {shift_q[13:0], mosi_s};
                  bit_cnt_q <= bit_cnt_q + SPI_CNT_W'(1);
                  if (mosi_s == SPI_RW_READ) begin
                     rd_q    <= rd_byte_c;
                     miso_oe <= 1'b1;
                  end
                  state_q <= DATA;
               end
            end

            DATA: begin
               if (cs_n_s) begin
                  frame_err <= 1'b1;
                  miso_oe   <= 1'b0;
                  miso      <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  if (sclk_fall && miso_oe) begin
                     miso <= rd_q[SPI_DATA_W-1];
                     rd_q <= {rd_q[SPI_DATA_W-2:0], 1'b0};
                  end
                  if (sclk_rise) begin
                     shift_q   <= {shift_q[13:0], mosi_s};
                     bit_cnt_q <= bit_cnt_q + SPI_CNT_W'(1);
                     if (bit_cnt_q == SPI_CNT_W'(SPI_FRAME_BITS - 1)) begin
                        if ((frame_rw_c != SPI_RW_READ) && frame_addr_ok_c) begin
                           for (int i = 0; i < int'(NUM_REGS); i++) begin
                              if (frame_addr_c == SPI_ADDR_W'(i)) regs_q[i] <= frame_data_c;
                           end
                           wr_pulse <= 1'b1;
                           wr_addr  <= frame_addr_c;
                           wr_data  <= frame_data_c;
                        end
                        frame_done <= 1'b1;
                        miso_oe    <= 1'b0;
                        miso       <= 1'b0;
                        state_q    <= DONE;
                     end
                  end
               end
            end

            DONE: begin
               if (cs_n_s) state_q <= IDLE;
            end

            default: state_q <= WAIT_IDLE;
         endcase
      end
   end

   assign regs_flat = regs_q;
endmodule

// File: tb/tb_spi_slave_regs.sv
// Randomized self-checking bench for spi_slave_regs against a frame-level model.
`timescale 1ns/1ps
module tb_spi_slave_regs;
   localparam int unsigned NUM_REGS = 16;
   localparam int          HALF     = 50;   // sclk half-period, 5 clk

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  sclk_in = 1'b1;
   logic                  cs_n_in = 1'b1;
   logic                  mosi = 1'b0;
   logic                  miso, miso_oe, wr_pulse, frame_done, frame_err;
   logic [6:0]            wr_addr;
   logic [7:0]            wr_data;
   logic [NUM_REGS*8-1:0] regs_flat;

   spi_slave_regs #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(2), .RESET_VAL(8'h00)) dut (
      .clk        (clk),
      .rst        (rst),
      .sclk_in    (sclk_in),
      .cs_n_in    (cs_n_in),
      .mosi       (mosi),
      .miso       (miso),
      .miso_oe    (miso_oe),
      .wr_pulse   (wr_pulse),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .regs_flat  (regs_flat)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int wr_tot = 0, done_tot = 0, err_tot = 0;
   logic [7:0] model [NUM_REGS];
   logic [6:0] last_wa;
   logic [7:0] last_wd;

   // Pulse counters sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_pulse)   wr_tot++;
      if (frame_done) done_tot++;
      if (frame_err)  err_tot++;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] model_flat();
      logic [127:0] v = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) v[i*8 +: 8] = model[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(NUM_REGS); i++) model[i] = 8'h00;
      last_wa = '0;
      last_wd = '0;
   endtask

   // One sclk period: fall, drive mosi, rise, master samples miso.
   task automatic sclk_bit(input logic b, inout logic [7:0] rx, inout int oe_cnt);
      sclk_in = 1'b0;
      mosi    = b;
      #(HALF);
      sclk_in = 1'b1;
      if (miso_oe) begin
         rx = {rx[6:0], miso};
         oe_cnt++;
      end
      #(HALF);
   endtask

   task automatic xfer(input logic [6:0] a, input logic r, input logic [7:0] d, input int nbits,
                       output logic [7:0] rx, output int oe_cnt);
      logic [15:0] f;
      f      = {a, r, d};
      rx     = '0;
      oe_cnt = 0;
      cs_n_in = 1'b0;
      #(HALF);
      for (int i = 0; i < nbits; i++) sclk_bit((i < 16) ? f[15-i] : 1'($urandom), rx, oe_cnt);
      cs_n_in = 1'b1;
      mosi    = 1'b0;
      #(3*HALF);
   endtask

   // Run a frame and compare every observable against the frame-level model.
   task automatic do_frame(input string nm, input logic [6:0] a, input logic r, input logic [7:0] d,
                           input int nbits);
      int w0, d0, e0, oe_cnt;
      logic [7:0] rx, exp_rx;
      logic full, in_range, exp_wr;
      w0 = wr_tot; d0 = done_tot; e0 = err_tot;
      in_range = int'(a) < int'(NUM_REGS);
      exp_rx   = in_range ? model[int'(a)] : 8'h00;
      xfer(a, r, d, nbits, rx, oe_cnt);
      full   = nbits >= 16;
      exp_wr = full && !r && in_range;
      if (exp_wr) begin
         model[int'(a)] = d;
         last_wa = a;
         last_wd = d;
      end
      check({nm, ".wr_cnt"},   128'(wr_tot - w0),   128'(exp_wr ? 1 : 0));
      check({nm, ".done_cnt"}, 128'(done_tot - d0), 128'(full ? 1 : 0));
      check({nm, ".err_cnt"},  128'(err_tot - e0),  128'(full ? 0 : 1));
      check({nm, ".wr_addr"},  128'(wr_addr),       128'(last_wa));
      check({nm, ".wr_data"},  128'(wr_data),       128'(last_wd));
      check({nm, ".regs"},     128'(regs_flat),     model_flat());
      if (full && r) begin
         check({nm, ".rd_data"}, 128'(rx),     128'(exp_rx));
         check({nm, ".oe_len"},  128'(oe_cnt), 128'(8));
      end
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] f;
      logic [7:0]  rx;
      int          oe_cnt, w0, d0, e0, nbits, sel;
      logic [6:0]  a;

      model_reset();
      #(40);
      check("rst.miso",       128'(miso),       128'(0));
      check("rst.miso_oe",    128'(miso_oe),    128'(0));
      check("rst.wr_pulse",   128'(wr_pulse),   128'(0));
      check("rst.frame_done", 128'(frame_done), 128'(0));
      check("rst.frame_err",  128'(frame_err),  128'(0));
      check("rst.wr_addr",    128'(wr_addr),    128'(0));
      check("rst.wr_data",    128'(wr_data),    128'(0));
      check("rst.regs",       128'(regs_flat),  model_flat());
      rst = 1'b0;
      #(200);

      do_frame("wr05", 7'h05, 1'b0, 8'hA5, 16);
      check("wr05.reg5", 128'(regs_flat[47:40]), 128'(8'hA5));
      do_frame("wr02", 7'h02, 1'b0, 8'h3C, 16);
      do_frame("rd02", 7'h02, 1'b1, 8'h00, 16);
      do_frame("rd7f", 7'h7F, 1'b1, 8'h00, 16);
      do_frame("wr7f", 7'h7F, 1'b0, 8'hFF, 16);
      do_frame("abort", 7'h01, 1'b0, 8'h55, 10);
      check("abort.reg1", 128'(regs_flat[15:8]), 128'(8'h00));
      do_frame("post_abort", 7'h01, 1'b0, 8'h55, 16);

      // Reset in the data phase, released with cs_n still low.
      f = {7'h04, 1'b0, 8'h99};
      rx = '0; oe_cnt = 0;
      cs_n_in = 1'b0;
      #(HALF);
      for (int i = 0; i < 12; i++) sclk_bit(f[15-i], rx, oe_cnt);
      rst = 1'b1;
      #(20);
      rst = 1'b0;
      model_reset();
      w0 = wr_tot; d0 = done_tot; e0 = err_tot;
      for (int i = 12; i < 16; i++) sclk_bit(f[15-i], rx, oe_cnt);
      cs_n_in = 1'b1;
      #(3*HALF);
      check("rstmid.wr_cnt",   128'(wr_tot - w0),   128'(0));
      check("rstmid.done_cnt", 128'(done_tot - d0), 128'(0));
      check("rstmid.err_cnt",  128'(err_tot - e0),  128'(0));
      check("rstmid.regs",     128'(regs_flat),     model_flat());
      do_frame("post_rst", 7'h04, 1'b0, 8'h99, 16);

      do_frame("extra_edges", 7'h03, 1'b0, 8'h81, 20);
      check("extra_edges.wr_data", 128'(wr_data), 128'(8'h81));

      for (int k = 0; k < 40; k++) begin
         sel = int'($urandom_range(0, 9));
         a = (sel == 0) ? 7'($urandom_range(NUM_REGS, 127)) : 7'($urandom_range(0, NUM_REGS-1));
         sel = int'($urandom_range(0, 9));
         nbits = (sel == 0) ? int'($urandom_range(1, 15)) :
                 (sel == 1) ? int'($urandom_range(17, 20)) : 16;
         do_frame($sformatf("rnd%0d", k), a, 1'($urandom), 8'($urandom), nbits);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
- SPI responder (slave) for the team's 16-bit SPI frame: 7-bit address MSB first, 1 R/W bit, then 8 data bits MSB first.
- Holds a local register bank. Writes update the bank. Reads return bank contents on MISO.
- Runs oversampled in the system clock domain and sits on the far end of the SPI master's sclk/cs_n/tx/rx wires.
- Provides a frame-level write notification to the fabric and a parallel view of all registers.

Parameters:
- NUM_REGS, 16, number of 8-bit registers; valid addresses 0..NUM_REGS-1 (NUM_REGS <= 128)
- SYNC_STAGES, 2, flip-flop stages on sclk_in, cs_n_in and mosi (>= 2)
- RESET_VAL, 8'h00, reset value of every register

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- sclk_in  input  1  SPI clock from master; idles high
- cs_n_in  input  1  SPI chip select from master, active low
- mosi  input  1  serial data from master
- miso  output  1  serial data to master
- miso_oe  output  1  high while slave drives miso (read data phase)
- wr_pulse  output  1  one-clk pulse when a write frame commits
- wr_addr  output  7  address of the committed write
- wr_data  output  8  data of the committed write
- frame_done  output  1  one-clk pulse on every complete 16-bit frame (read or write)
- frame_err  output  1  one-clk pulse when cs_n rises mid-frame
- regs_flat  output  NUM_REGS*8  register bank; reg i at bits [8i+7:8i]

Behaviour:
- Reset: all outputs 0; every register = RESET_VAL; FSM = WAIT_IDLE; synchronizers = sclk 1, cs_n 1, mosi 0.
- Clock ratio: sclk half-period must be >= 4 clk cycles. Edge detection uses the last two synchronized sclk samples.
- Sampling: mosi is sampled on each synchronized sclk rising edge. miso updates on each synchronized sclk falling edge. Effective latency from a pin edge is SYNC_STAGES+1 clk.
- FSM states:
  - WAIT_IDLE: stays until sync cs_n = 1, then goes to IDLE. Entered after reset, so a frame already in progress at reset release is never decoded.
  - IDLE: on a cs_n falling edge, clear bit_cnt (4 bit) and the shift register, then go to ADDR.
  - ADDR: on each sclk rising edge, shift in mosi and increment bit_cnt. After 7 bits, go to RW.
  - RW: on the rising edge, capture rw (1 = read, 0 = write).
    - For a read, latch rd_byte = reg[addr] (0x00 if addr >= NUM_REGS).
    - Go to DATA.
  - DATA: on each rising edge, shift in mosi.
    - For a read, miso_oe = 1. rd_byte[7] is driven on the first falling edge after RW, then bits 6..0 on the following falling edges.
    - On the 16th rising edge:
      - Write with addr < NUM_REGS: reg[addr] <= data, and wr_pulse/wr_addr/wr_data are asserted in the same clk.
      - Write with addr >= NUM_REGS: the write is dropped and wr_pulse stays 0.
      - In both cases frame_done pulses and the FSM goes to DONE.
  - DONE: ignores further sclk edges; miso_oe = 0, miso = 0. On cs_n high, go to IDLE.
- Abort: sync cs_n = 1 in ADDR, RW or DATA raises frame_err for 1 clk. No register change, no wr_pulse; miso_oe drops in the same clk and the FSM goes to IDLE.
- Outside a read DATA phase, miso = 0 and miso_oe = 0.
- wr_addr and wr_data hold their last committed values between pulses.
- rd_byte is latched at RW, so a read returns the pre-frame value. Only SPI writes change the bank, so no fabric write can collide with it.
- Reset mid-frame clears everything immediately (async); the FSM returns to WAIT_IDLE.
- Back-to-back frames (cs_n high for >= 1 sclk half-period) are each decoded independently.

Decomposition:
- Shared package spi_pkg:
  - constants SPI_ADDR_W = 7, SPI_DATA_W = 8, SPI_FRAME_BITS = 16, SPI_RW_READ = 1'b1
  - FSM state enum (WAIT_IDLE, IDLE, ADDR, RW, DATA, DONE)
- One sub-module, spi_sync_edge: an SYNC_STAGES synchronizer plus rise/fall pulse detector. It is instantiated for sclk_in and cs_n_in; mosi uses the synchronizer path only.

Test Plan:
- Write addr 0x05 data 0xA5 -> wr_pulse once with wr_addr = 0x05 and wr_data = 0xA5; regs_flat[47:40] = 0xA5; frame_done once; frame_err = 0.
- Write 0x3C to addr 0x02, then read addr 0x02 -> MISO bits over the data phase = 0,0,1,1,1,1,0,0; miso_oe high for exactly 8 sclk periods; no wr_pulse on the read.
- Read addr 0x7F (out of range) -> MISO returns 0x00. Write 0xFF to 0x7F -> no wr_pulse, regs_flat unchanged, frame_done pulses.
- Raise cs_n after 10 bits of a write to addr 0x01 with data 0x55 -> frame_err 1 clk, reg[1] stays RESET_VAL, next full frame decodes correctly.
- Assert rst while in the DATA phase of a write, release with cs_n still low, then finish the frame -> no write, no frame_done; next frame after cs_n high decodes normally.
- 20 sclk edges inside one cs_n window on a write of 0x81 to addr 0x03 -> exactly one wr_pulse with data 0x81; extra edges are ignored.
